// File: rtl/sorted_batch_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sorted_batch_issuer                                          |
// | Description : Captures one pre-sorted batch of four addresses and issues   |
// |               them one per handshake, descending or ascending, flagging    |
// |               the last request. Optional macro SORTED_BATCH_DEDUP_EN       |
// |               suppresses entries equal to the previously issued one.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sorted_batch_issuer #(
   parameter int ADDR_W    = 12,
   parameter int ISSUE_ASC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              batch_valid,
   output logic              batch_ready,
   input  logic [ADDR_W-1:0] batch_in0,
   input  logic [ADDR_W-1:0] batch_in1,
   input  logic [ADDR_W-1:0] batch_in2,
   input  logic [ADDR_W-1:0] batch_in3,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [ADDR_W-1:0] req_addr,
   output logic              req_last,
   output logic              busy
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam logic c_asc = (ISSUE_ASC != 0);

   state_t            r_state;
   logic [ADDR_W-1:0] r_entry [4];
   logic [1:0]        r_index;
   logic [1:0]        r_last_idx;
   logic [3:0]        r_keep;
   logic              r_batch_ready;
   logic              r_req_valid;
   logic [ADDR_W-1:0] r_req_addr;
   logic              r_req_last;
   logic              r_busy;

   logic [ADDR_W-1:0] w_in  [4];
   logic [ADDR_W-1:0] w_cap [4];
   logic [3:0]        w_keep;
   logic [1:0]        w_cap_last;
   logic [1:0]        w_next_idx;
   logic              w_capture;
   logic              w_fire;

   // Issue position k maps to batch slot k (descending) or 3-k (ascending).
   function automatic logic [1:0] f_pos(input logic [1:0] idx);
      return c_asc ? ~idx : idx;
   endfunction

   function automatic logic [1:0] f_next_kept(input logic [3:0] keep,
                                              input logic [1:0] idx);
      logic [1:0] nxt;
      nxt = idx;
      for (int k = 3; k >= 1; k--) begin
         if ((2'(k) > idx) && keep[k]) begin
            nxt = 2'(k);
         end
      end
      return nxt;
   endfunction

   function automatic logic [1:0] f_last_kept(input logic [3:0] keep);
      logic [1:0] last;
      last = 2'd0;
      for (int k = 1; k < 4; k++) begin
         if (keep[k]) begin
            last = 2'(k);
         end
      end
      return last;
   endfunction

   assign w_in[0] = batch_in0;
   assign w_in[1] = batch_in1;
   assign w_in[2] = batch_in2;
   assign w_in[3] = batch_in3;

   // Entries are held in issue order, so the issue index addresses them directly.
   for (genvar k = 0; k < 4; k++) begin : g_cap
      assign w_cap[k] = w_in[f_pos(2'(k))];
   end

`ifdef SORTED_BATCH_DEDUP_EN
   assign w_keep[0] = 1'b1;
   for (genvar k = 1; k < 4; k++) begin : g_keep
      assign w_keep[k] = (w_cap[k] != w_cap[k-1]);
   end
`else
   assign w_keep = 4'b1111;
`endif

   assign w_cap_last = f_last_kept(w_keep);
   assign w_next_idx = f_next_kept(r_keep, r_index);
   assign w_capture  = batch_valid && r_batch_ready;
   assign w_fire     = r_req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_index       <= 2'd0;
         r_last_idx    <= 2'd0;
         r_keep        <= 4'd0;
         for (int k = 0; k < 4; k++) begin
            r_entry[k] <= '0;
         end
         r_batch_ready <= 1'b1;
         r_req_valid   <= 1'b0;
         r_req_addr    <= '0;
         r_req_last    <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_capture) begin
                  for (int k = 0; k < 4; k++) begin
                     r_entry[k] <= w_cap[k];
                  end
                  r_keep        <= w_keep;
                  r_last_idx    <= w_cap_last;
                  r_index       <= 2'd0;
                  r_req_addr    <= w_cap[0];
                  r_req_last    <= (w_cap_last == 2'd0);
                  r_req_valid   <= 1'b1;
                  r_busy        <= 1'b1;
                  r_batch_ready <= 1'b0;
                  r_state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (w_fire) begin
                  if (r_req_last) begin
                     r_req_valid   <= 1'b0;
                     r_req_addr    <= '0;
                     r_req_last    <= 1'b0;
                     r_busy        <= 1'b0;
                     r_batch_ready <= 1'b1;
                     r_state       <= IDLE;
                  end else begin
                     // Skipped positions never reach req_addr: jump straight to the next kept one.
                     r_index    <= w_next_idx;
                     r_req_addr <= r_entry[w_next_idx];
                     r_req_last <= (w_next_idx == r_last_idx);
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign batch_ready = r_batch_ready;
   assign req_valid   = r_req_valid;
   assign req_addr    = r_req_addr;
   assign req_last    = r_req_last;
   assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sorted_batch_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sorted_batch_issuer                                       |
// | Description : Self-checking bench; descending and ascending instances fed  |
// |               the same batches, checked against a queue of expected reqs.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sorted_batch_issuer;

   typedef struct {
      logic [11:0] addr;
      logic        last;
   } exp_t;

   typedef struct {
      logic [11:0] a0;
      logic [11:0] a1;
      logic [11:0] a2;
      logic [11:0] a3;
      logic [15:0] pat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        batch_valid = 1'b0;
   logic        req_ready = 1'b0;
   logic [11:0] in_a [4];
   logic [1:0]  br, rv, rl, bz;
   logic [11:0] ra [2];

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;
   logic [1:0]  hold = 2'b00;
   logic [11:0] ha [2];
   logic [1:0]  hl;
   vec_t vt [6];

   always #5 clk = ~clk;

   sorted_batch_issuer #(.ADDR_W(12), .ISSUE_ASC(0)) u_desc (
      .clk(clk), .rst(rst), .batch_valid(batch_valid), .batch_ready(br[0]),
      .batch_in0(in_a[0]), .batch_in1(in_a[1]), .batch_in2(in_a[2]), .batch_in3(in_a[3]),
      .req_valid(rv[0]), .req_ready(req_ready), .req_addr(ra[0]), .req_last(rl[0]), .busy(bz[0])
   );

   sorted_batch_issuer #(.ADDR_W(12), .ISSUE_ASC(1)) u_asc (
      .clk(clk), .rst(rst), .batch_valid(batch_valid), .batch_ready(br[1]),
      .batch_in0(in_a[0]), .batch_in1(in_a[1]), .batch_in2(in_a[2]), .batch_in3(in_a[3]),
      .req_valid(rv[1]), .req_ready(req_ready), .req_addr(ra[1]), .req_last(rl[1]), .busy(bz[1])
   );

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, req, $time);
      end
   endtask

   function automatic int n_kept(input logic [11:0] a0, a1, a2, a3);
      int n;
`ifdef SORTED_BATCH_DEDUP_EN
      n = 1 + int'(a1 != a0) + int'(a2 != a1) + int'(a3 != a2);
`else
      n = 4;
`endif
      return n;
   endfunction

   // Expected request stream for dut d (0: descending, 1: ascending).
   task automatic push_batch(input int d);
      logic [11:0] v [4];
      logic [3:0]  keep;
      int          last;
      exp_t        e;
      for (int k = 0; k < 4; k++) v[k] = (d == 1) ? in_a[3-k] : in_a[k];
      keep[0] = 1'b1;
      for (int k = 1; k < 4; k++) begin
`ifdef SORTED_BATCH_DEDUP_EN
         keep[k] = (v[k] != v[k-1]);
`else
         keep[k] = 1'b1;
`endif
      end
      last = 0;
      for (int k = 1; k < 4; k++) if (keep[k]) last = k;
      for (int k = 0; k < 4; k++) begin
         if (keep[k]) begin
            e.addr = v[k];
            e.last = (k == last);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q0.delete();
         q1.delete();
         hold = 2'b00;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (hold[d]) begin
               chk("hold_valid", d, 32'(rv[d]), 32'd1);
               chk("hold_addr", d, 32'(ra[d]), 32'(ha[d]));
               chk("hold_last", d, 32'(rl[d]), 32'(hl[d]));
            end
            chk("busy_vs_ready", d, 32'(bz[d]), 32'(br[d] == 1'b0));
            if (rv[d] && req_ready) begin
               if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                  chk("unexpected_req", d, 32'(ra[d]), 32'hFFFF_FFFF);
               end else begin
                  e = (d == 0) ? q0.pop_front() : q1.pop_front();
                  chk("req_addr", d, 32'(ra[d]), 32'(e.addr));
                  chk("req_last", d, 32'(rl[d]), 32'(e.last));
               end
            end
            hold[d] = rv[d] && !req_ready;
            ha[d]   = ra[d];
            hl[d]   = rl[d];
            if (batch_valid && br[d]) push_batch(d);
         end
      end
   end

   task automatic run_batch(input vec_t v);
      int t;
      int cnt;
      int cyc;
      int n;
      n = n_kept(v.a0, v.a1, v.a2, v.a3);
      t = 0;
      cnt = 0;
      while (cnt < n && t < 40) begin
         if (t >= 16 || v.pat[t]) cnt++;
         t++;
      end
      @(posedge clk); #1;
      chk("idle_before_batch", 0, 32'(br), 32'd3);
      in_a[0] = v.a0; in_a[1] = v.a1; in_a[2] = v.a2; in_a[3] = v.a3;
      batch_valid = 1'b1;
      req_ready = 1'b0;
      @(posedge clk); #1;
      // Garbage offered while busy must be ignored.
      in_a[0] = 12'hEEE; in_a[1] = 12'hDDD; in_a[2] = 12'hCCC; in_a[3] = 12'hBBB;
      req_ready = v.pat[0];
      @(negedge clk);
      chk("first_req_latency", 0, 32'(rv), 32'd3);
      cyc = 0;
      while (cyc < 40) begin
         if (br == 2'b11) break;
         cyc++;
         @(posedge clk); #1;
         batch_valid = 1'b0;
         req_ready = (cyc < 16) ? v.pat[cyc] : 1'b1;
         @(negedge clk);
      end
      chk("issue_cycles", 0, 32'(cyc), 32'(t));
      chk("queue0_drained", 0, 32'(q0.size()), 32'd0);
      chk("queue1_drained", 1, 32'(q1.size()), 32'd0);
      req_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t r;
      vt[0] = '{12'hF00, 12'h800, 12'h100, 12'h005, 16'hFFFF};
      vt[1] = '{12'hF00, 12'h800, 12'h100, 12'h005, 16'hFFF1};
      vt[2] = '{12'h030, 12'h020, 12'h010, 12'h000, 16'hFFFF};
      vt[3] = '{12'h200, 12'h200, 12'h100, 12'h100, 16'hFFFF};
      vt[4] = '{12'h007, 12'h007, 12'h007, 12'h007, 16'hFFFF};
      vt[5] = '{12'hABC, 12'hABC, 12'h123, 12'h001, 16'hAAAA};
      for (int k = 0; k < 4; k++) in_a[k] = 12'h000;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_batch_ready", d, 32'(br[d]), 32'd1);
         chk("rst_req_valid", d, 32'(rv[d]), 32'd0);
         chk("rst_req_addr", d, 32'(ra[d]), 32'd0);
         chk("rst_req_last", d, 32'(rl[d]), 32'd0);
         chk("rst_busy", d, 32'(bz[d]), 32'd0);
      end

      for (int i = 0; i < 6; i++) run_batch(vt[i]);

      // Reset after the second handshake discards the rest of the batch.
      @(posedge clk); #1;
      in_a[0] = 12'hF00; in_a[1] = 12'h800; in_a[2] = 12'h100; in_a[3] = 12'h005;
      batch_valid = 1'b1;
      @(posedge clk); #1;
      batch_valid = 1'b0;
      req_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      req_ready = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("midrst_req_valid", d, 32'(rv[d]), 32'd0);
         chk("midrst_batch_ready", d, 32'(br[d]), 32'd1);
         chk("midrst_busy", d, 32'(bz[d]), 32'd0);
         chk("midrst_req_addr", d, 32'(ra[d]), 32'd0);
      end
      r = '{12'h004, 12'h003, 12'h002, 12'h001, 16'hFFFF};
      run_batch(r);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("final_idle", 0, 32'(br), 32'd3);
      chk("final_no_req", 0, 32'(rv), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
